// File: rtl/regfile_op_sequencer.sv
// Purpose : control FSM between switch/button front end and the RegFile+ALU datapath.
// Ports   : clk/rst; data_input + ld_Reg/ld_Setup/ld_Imm load strobes; en go strobe;
//           regfile addr/we/wb_sel, imm_out, alu_op/use_imm/flags_we, busy/done/err.
module regfile_op_sequencer #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 10,
    parameter int NREG   = 16,
    parameter int AW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   data_input,
    input  logic              ld_Reg,
    input  logic              ld_Setup,
    input  logic              ld_Imm,
    input  logic              en,
    output logic [AW-1:0]     rf_raddrA,
    output logic [AW-1:0]     rf_raddrB,
    output logic [AW-1:0]     rf_waddr,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic [DATA_W-1:0] imm_out,
    output logic [3:0]        alu_op,
    output logic              use_imm,
    output logic              flags_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);
    localparam logic [3:0]    OP_MOV   = 4'h7;
    localparam logic [3:0]    OP_CLR   = 4'h8;
    localparam logic [3:0]    OP_LDI   = 4'h9;
    localparam logic [3:0]    OP_ADDI  = 4'hA;
    localparam logic [3:0]    OP_SUBI  = 4'hB;

    state_t          state, state_nxt;
    logic [AW-1:0]   rdest, rsrc, cnt;
    logic [3:0]      opcode;
    logic [IN_W-1:0] imm;

    logic any_ld, idle, accept_en, reserved, clr_last;
    logic [3:0] alu_code;
    logic       imm_op, sets_flags, writes_reg;
    logic [1:0] wb_code;

    assign idle      = (state == S_IDLE);
    assign any_ld    = ld_Reg | ld_Setup | ld_Imm;
    // Loads win over a simultaneous go strobe; the go is simply dropped.
    assign accept_en = idle & en & ~any_ld;
    assign reserved  = (opcode >= 4'hC);
    assign clr_last  = (state == S_CLR) && (cnt == LAST_REG);

    assign rf_raddrA = rdest;
    assign rf_raddrB = rsrc;
    assign imm_out   = {{(DATA_W-IN_W){1'b0}}, imm};
    assign busy      = ~idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Operand latches, clear counter and the done/err flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdest  <= '0;
            rsrc   <= '0;
            opcode <= '0;
            imm    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (idle && ld_Reg) begin
                rdest <= data_input[7:4];
                rsrc  <= data_input[3:0];
            end
            if (idle && ld_Setup) opcode <= data_input[7:4];
            if (idle && ld_Imm)   imm    <= data_input;

            if (state == S_DEC)      cnt <= '0;
            else if (state == S_CLR) cnt <= cnt + 1'b1;

            done <= (state == S_WB) || clr_last;

            if (accept_en)                       err <= 1'b0;
            else if (state == S_DEC && reserved) err <= 1'b1;
        end
    end

    always_comb begin
        // Opcode decode, shared by EXEC and WB.
        alu_code   = 4'h0;
        imm_op     = 1'b0;
        sets_flags = 1'b0;
        writes_reg = 1'b0;
        wb_code    = 2'd0;
        if (opcode >= 4'h1 && opcode <= 4'h6) begin
            alu_code   = opcode;
            sets_flags = 1'b1;
            writes_reg = (opcode != 4'h6);
        end
        if (opcode == OP_ADDI || opcode == OP_SUBI) begin
            alu_code   = (opcode == OP_ADDI) ? 4'h1 : 4'h2;
            imm_op     = 1'b1;
            sets_flags = 1'b1;
            writes_reg = 1'b1;
        end
        if (opcode == OP_MOV) begin
            writes_reg = 1'b1;
            wb_code    = 2'd3;
        end
        if (opcode == OP_LDI) begin
            writes_reg = 1'b1;
            wb_code    = 2'd1;
        end

        state_nxt = state;
        rf_waddr  = '0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        alu_op    = 4'h0;
        use_imm   = 1'b0;
        flags_we  = 1'b0;

        case (state)
            S_IDLE: if (accept_en) state_nxt = S_DEC;
            S_DEC: begin
                if (reserved)              state_nxt = S_IDLE;
                else if (opcode == OP_CLR) state_nxt = S_CLR;
                else                       state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_op    = alu_code;
                use_imm   = imm_op;
                flags_we  = sets_flags;
                state_nxt = S_WB;
            end
            S_WB: begin
                // ALU controls stay stable so the result is still valid at the write.
                alu_op    = alu_code;
                use_imm   = imm_op;
                rf_we     = writes_reg;
                rf_waddr  = rdest;
                wb_sel    = wb_code;
                state_nxt = S_IDLE;
            end
            S_CLR: begin
                rf_we    = 1'b1;
                wb_sel   = 2'd2;
                rf_waddr = cnt;
                if (cnt == LAST_REG) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Purpose : randomized self-checking bench for regfile_op_sequencer against a trace model.
// Ports   : none; drives every DUT port and compares all outputs once per cycle.
module tb_regfile_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  data_input;
    logic        ld_Reg, ld_Setup, ld_Imm, en;
    logic [3:0]  rf_raddrA, rf_raddrB, rf_waddr, alu_op;
    logic        rf_we, use_imm, flags_we, busy, done, err;
    logic [1:0]  wb_sel;
    logic [15:0] imm_out;

    regfile_op_sequencer dut (
        .clk(clk), .rst(rst), .data_input(data_input),
        .ld_Reg(ld_Reg), .ld_Setup(ld_Setup), .ld_Imm(ld_Imm), .en(en),
        .rf_raddrA(rf_raddrA), .rf_raddrB(rf_raddrB), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .wb_sel(wb_sel), .imm_out(imm_out), .alu_op(alu_op),
        .use_imm(use_imm), .flags_we(flags_we), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        rf_we;
        logic [3:0]  waddr;
        logic [1:0]  wb_sel;
        logic [3:0]  alu_op;
        logic        use_imm;
        logic        flags_we;
        logic        done;
        logic        err;
        logic [3:0]  raddr_a;
        logic [3:0]  raddr_b;
        logic [15:0] imm;
    } obs_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural model state.
    logic [3:0] m_rdest, m_rsrc, m_op;
    logic [9:0] m_imm;
    logic       m_err;
    obs_t       exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample();
        obs_t r;
        r.busy = busy; r.rf_we = rf_we; r.waddr = rf_waddr; r.wb_sel = wb_sel;
        r.alu_op = alu_op; r.use_imm = use_imm; r.flags_we = flags_we;
        r.done = done; r.err = err; r.raddr_a = rf_raddrA; r.raddr_b = rf_raddrB;
        r.imm = imm_out;
        return r;
    endfunction

    function automatic obs_t base();
        obs_t r = '0;
        r.raddr_a = m_rdest;
        r.raddr_b = m_rsrc;
        r.imm     = {6'b0, m_imm};
        r.err     = m_err;
        return r;
    endfunction

    // Instruction-set rules, written as opcode tables.
    function automatic bit op_writes(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB};
    endfunction
    function automatic bit op_flags(input logic [3:0] op);
        return op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    endfunction
    function automatic logic [3:0] op_alu(input logic [3:0] op);
        if (op >= 4'h1 && op <= 4'h6) return op;
        if (op == 4'hA) return 4'h1;
        if (op == 4'hB) return 4'h2;
        return 4'h0;
    endfunction
    function automatic logic [1:0] op_wsel(input logic [3:0] op);
        if (op == 4'h7) return 2'd3;
        if (op == 4'h9) return 2'd1;
        return 2'd0;
    endfunction

    // Expected per-cycle outputs, starting with the cycle right after the go edge.
    task automatic build_exp();
        obs_t r;
        exp_q.delete();
        m_err = 1'b0;
        r = base(); r.busy = 1'b1; exp_q.push_back(r);          // decode
        if (m_op >= 4'hC) begin
            m_err = 1'b1;
            exp_q.push_back(base());
            exp_q.push_back(base());
        end else if (m_op == 4'h8) begin
            for (int k = 0; k < 16; k++) begin
                r = base(); r.busy = 1'b1; r.rf_we = 1'b1; r.wb_sel = 2'd2;
                r.waddr = 4'(k);
                exp_q.push_back(r);
            end
            r = base(); r.done = 1'b1; exp_q.push_back(r);
            exp_q.push_back(base());
        end else begin
            r = base(); r.busy = 1'b1; r.alu_op = op_alu(m_op);
            r.use_imm = (m_op == 4'hA || m_op == 4'hB); r.flags_we = op_flags(m_op);
            exp_q.push_back(r);
            r.flags_we = 1'b0; r.rf_we = op_writes(m_op); r.waddr = m_rdest;
            r.wb_sel = op_wsel(m_op);
            exp_q.push_back(r);
            r = base(); r.done = 1'b1; exp_q.push_back(r);
            exp_q.push_back(base());
        end
    endtask

    // Issue go and compare every cycle; optional strobes injected while busy.
    task automatic run_op(input string name, input int en_at, input int ld_at,
                          input logic [9:0] ld_val);
        obs_t got;
        en = 1'b1; tick(); en = 1'b0;
        build_exp();
        for (int i = 0; i < exp_q.size(); i++) begin
            got = sample();
            n_checks++;
            if (got !== exp_q[i])
                $display("FAIL %s op=%h cycle=%0d got=%h exp=%h", name, m_op, i, got, exp_q[i]);
            else
                n_pass++;
            if (i < exp_q.size() - 1) begin
                if (i == en_at && i < exp_q.size() - 2) en = 1'b1;
                if (i == ld_at && i < exp_q.size() - 2) begin
                    ld_Reg = 1'b1; data_input = ld_val;
                end
                tick();
                en = 1'b0; ld_Reg = 1'b0;
            end
        end
    endtask

    // Load strobes from IDLE; a simultaneous go is expected to be dropped.
    task automatic do_load(input string name, input logic lr, input logic ls,
                           input logic li, input logic [9:0] d, input logic e);
        obs_t got;
        ld_Reg = lr; ld_Setup = ls; ld_Imm = li; data_input = d; en = e;
        tick();
        ld_Reg = 1'b0; ld_Setup = 1'b0; ld_Imm = 1'b0; en = 1'b0;
        if (lr) begin m_rdest = d[7:4]; m_rsrc = d[3:0]; end
        if (ls) m_op = d[7:4];
        if (li) m_imm = d;
        got = sample();
        n_checks++;
        if (got !== base()) $display("FAIL %s got=%h exp=%h", name, got, base());
        else n_pass++;
    endtask

    task automatic model_reset();
        m_rdest = '0; m_rsrc = '0; m_op = '0; m_imm = '0; m_err = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1; data_input = 10'h3FF; ld_Reg = 1'b1; ld_Setup = 1'b1; ld_Imm = 1'b1; en = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            got = sample();
            n_checks++;
            if (got !== '0) $display("FAIL reset_hold cycle=%0d got=%h exp=0", i, got);
            else n_pass++;
            en = 1'b1;
            tick();
        end
        ld_Reg = 1'b0; ld_Setup = 1'b0; ld_Imm = 1'b0; en = 1'b0; data_input = '0;
        rst = 1'b0;
        tick();
        got = sample();
        n_checks++;
        if (got !== base()) $display("FAIL reset_release got=%h exp=%h", got, base());
        else n_pass++;
    endtask

    task automatic test_clear();
        do_load("clr_setup", 1'b0, 1'b1, 1'b0, 10'h080, 1'b0);
        run_op("clear_sweep", -1, -1, '0);
    endtask

    task automatic test_ldi();
        do_load("ldi_reg", 1'b1, 1'b0, 1'b0, 10'h001, 1'b0);
        do_load("ldi_imm", 1'b0, 1'b0, 1'b1, 10'h001, 1'b0);
        do_load("ldi_setup", 1'b0, 1'b1, 1'b0, 10'h090, 1'b0);
        run_op("ldi", -1, -1, '0);
    endtask

    task automatic test_add_cmp();
        do_load("add_reg", 1'b1, 1'b0, 1'b0, 10'h012, 1'b0);
        do_load("add_setup", 1'b0, 1'b1, 1'b0, 10'h010, 1'b0);
        run_op("add", -1, -1, '0);
        do_load("cmp_setup", 1'b0, 1'b1, 1'b0, 10'h060, 1'b0);
        run_op("cmp", -1, -1, '0);
    endtask

    task automatic test_reserved();
        do_load("rsv_setup", 1'b0, 1'b1, 1'b0, 10'h0C0, 1'b0);
        run_op("reserved", -1, -1, '0);
        do_load("valid_setup", 1'b0, 1'b1, 1'b0, 10'h010, 1'b0);
        run_op("err_clear", -1, -1, '0);
    endtask

    task automatic test_midop_strobes();
        do_load("mid_setup", 1'b0, 1'b1, 1'b0, 10'h010, 1'b0);
        run_op("midop_strobes", 1, 2, 10'h0FF);
        do_load("imm_and_en", 1'b0, 1'b0, 1'b1, 10'h2A5, 1'b1);
    endtask

    task automatic test_reset_midclr();
        obs_t got;
        do_load("rclr_setup", 1'b0, 1'b1, 1'b0, 10'h080, 1'b0);
        en = 1'b1; tick(); en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (rf_waddr !== 4'd5 || rf_we !== 1'b1)
            $display("FAIL clr_pre_abort waddr=%0d we=%b exp waddr=5 we=1", rf_waddr, rf_we);
        else n_pass++;
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            got = sample();
            n_checks++;
            if (got !== '0) $display("FAIL clr_abort cycle=%0d got=%h exp=0", i, got);
            else n_pass++;
            tick();
        end
        rst = 1'b0;
        tick();
        got = sample();
        n_checks++;
        if (got !== base()) $display("FAIL clr_after_abort got=%h exp=%h", got, base());
        else n_pass++;
        do_load("rclr_setup2", 1'b0, 1'b1, 1'b0, 10'h080, 1'b0);
        run_op("clear_restart", -1, -1, '0);
    endtask

    task automatic test_random();
        logic [9:0] d;
        logic [2:0] m;
        for (int it = 0; it < 40; it++) begin
            d = 10'($urandom_range(0, 1023));
            m = 3'($urandom_range(1, 7));
            do_load("rand_load", m[0], m[1], m[2], d, 1'($urandom_range(0, 1)));
            run_op("rand_op", $urandom_range(0, 3), $urandom_range(0, 3),
                   10'($urandom_range(0, 1023)));
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_ldi();
        test_add_cmp();
        test_reserved();
        test_midop_strobes();
        test_reset_midclr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Control FSM between the switch/button front end and the RegFile+ALU datapath.
- Latches the operand-select, setup/opcode and immediate fields from the 10-bit switch bus on their load strobes.
- On a go strobe, runs a fixed multi-cycle decode/execute/writeback sequence, or a 16-cycle clear-all sweep, driving regfile addresses, write enable, ALU opcode, immediate mux and flag write.
- The datapath itself (regfile array, ALU, flags register, 7-seg decode) is outside this block.

Parameters:
- DATA_W, 16, datapath word width; the immediate is zero-extended to this width.
- IN_W, 10, switch bus width.
- NREG, 16, register count; address width AW = 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- data_input  in  IN_W  switch bus.
- ld_Reg  in  1  latch Rdest=data_input[7:4], Rsrc=data_input[3:0].
- ld_Setup  in  1  latch opcode=data_input[7:4].
- ld_Imm  in  1  latch imm=data_input[9:0].
- en  in  1  go strobe, level-sampled.
- rf_raddrA  out  AW  read port A address; always equals Rdest.
- rf_raddrB  out  AW  read port B address; always equals Rsrc.
- rf_waddr  out  AW  write address.
- rf_we  out  1  regfile write enable.
- wb_sel  out  2  write data select: 0 = ALU, 1 = imm, 2 = zero, 3 = port B.
- imm_out  out  DATA_W  zero-extended immediate.
- alu_op  out  4  ALU function code.
- use_imm  out  1  ALU operand B = imm_out.
- flags_we  out  1  flags register load.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  reserved-opcode flag, sticky.

Behaviour:
- Reset: async. State goes to IDLE. Rdest, Rsrc, opcode, imm, clear counter, done and err all clear to 0. Every output is 0 while rst is high.
- Loads: accepted only in IDLE, at the rising edge, each strobe independently. Several strobes in the same cycle all load. Strobes while busy are ignored.
- en: accepted only in IDLE with no ld_* strobe in the same cycle; loads take priority and en is dropped. en while busy is ignored. Acceptance clears err.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 CMP: flags only, no write
  - 7 MOV: Rsrc to Rdest
  - 8 CLR: all registers
  - 9 LDI
  - A ADDI, B SUBI
  - C-F reserved
- States: IDLE, DEC, EXEC, WB, CLR.
- IDLE to DEC on accepted en (edge E0).
- DEC (cycle after E0):
  - reserved opcode goes to IDLE with err=1 and no done;
  - opcode 8 goes to CLR with counter=0;
  - all other opcodes go to EXEC.
- EXEC (1 cycle):
  - alu_op = opcode for 1-6;
  - alu_op = 1 for ADDI, 2 for SUBI, with use_imm=1;
  - flags_we=1 for opcodes 1-6, A, B.
  - Next state WB.
- WB (1 cycle):
  - rf_waddr = Rdest.
  - rf_we=1 for opcodes 1-5, 7, 9, A, B.
  - wb_sel = 3 for MOV, 1 for LDI, 0 otherwise.
  - alu_op/use_imm are held from EXEC.
  - Next state IDLE with done=1 for that one IDLE cycle.
- Result: for a normal op, rf_we is high in the cycle beginning at E2, the write lands at E3, and done is high in the cycle after E3. NOP and CMP follow the same timing with rf_we=0.
- CLR (16 cycles): rf_we=1, wb_sel=2, rf_waddr = counter. The counter increments 0 to 15, then the block goes to IDLE with done=1. The counter does not wrap within a sweep.
- imm_out is driven continuously from the latch.
- Mid-operation rst aborts immediately. Any rf_we in flight is dropped and no done pulse is issued.

Test Plan:
1. Apply reset; ld_Setup with 0x080; en -> busy for 17 cycles, rf_we high 16 consecutive cycles with rf_waddr 0..15 and wb_sel=2, then done pulse and busy=0.
2. ld_Reg 0x001, ld_Imm 0x001, ld_Setup 0x090; en -> rf_we exactly one cycle at the E2 edge, rf_waddr=0, wb_sel=1, imm_out=0x0001, done the following cycle.
3. ld_Reg 0x012, ld_Setup 0x010; en -> EXEC: alu_op=1, flags_we=1, use_imm=0, rf_raddrA=1, rf_raddrB=2; WB: rf_we=1, rf_waddr=1, wb_sel=0. CMP (0x060) gives the same sequence with rf_we never high.
4. ld_Setup 0x0C0; en -> err=1 two cycles after E0, no rf_we, no done. A subsequent valid en clears err.
5. Mid-operation strobes: en during EXEC, and ld_Reg 0x0FF during WB -> both ignored; Rdest is unchanged after done. ld_Imm and en in the same IDLE cycle -> imm loads, busy stays 0.
6. Assert rst during CLR at counter=5 -> all outputs 0 immediately; no done; the next CLR restarts at rf_waddr=0.
